// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: segment patterns,
// digit register width and requester identifiers.
package seg_pkg;

  localparam int unsigned DIGIT_W = 5;  // {dp, hex value}

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Bit order {g,f,e,d,c,b,a}, 1 = segment lit.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment pattern decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    unique case (val)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with PWM brightness, anode dead time
// and a round-robin two-requester write port into the digit register file.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                req_a,
  input  logic [1:0]          idx_a,
  input  logic [3:0]          val_a,
  input  logic                dp_a,
  input  logic                req_b,
  input  logic [1:0]          idx_b,
  input  logic [3:0]          val_b,
  input  logic                dp_b,
  output logic                gnt_a,
  output logic                gnt_b,
  input  logic [3:0]          bright,
  output logic [N_DIGITS-1:0] an,
  output logic [7:0]          ca
);

  // The slot divider is split into a prescaler and a 16-step PWM phase counter,
  // so the phase is div_cnt / (SCAN_DIV/16) without a divider.
  localparam int unsigned      PreDiv = SCAN_DIV / 16;
  localparam int unsigned      PreW   = (PreDiv > 1) ? $clog2(PreDiv) : 1;
  localparam logic [PreW-1:0]  PreMax = PreW'(PreDiv - 1);
  localparam int unsigned      SelW   = $clog2(N_DIGITS);
  localparam logic [SelW-1:0]  SelMax = SelW'(N_DIGITS - 1);

  logic [PreW-1:0]    pre_q, pre_d;
  logic [3:0]         sub_q, sub_d;
  logic [SelW-1:0]    sel_q, sel_d;
  logic [3:0]         bright_q, bright_d;
  logic               last_gnt_q, last_gnt_d;
  logic [DIGIT_W-1:0] digit_q [N_DIGITS];

  logic               elig_a, elig_b, win_a, win_b;
  logic               slot_start;
  logic [DIGIT_W-1:0] cur_digit;
  logic [6:0]         seg;
  logic [N_DIGITS-1:0] an_d;
  logic [7:0]         ca_d;

  // A requester granted last cycle sits out one cycle, capping each at 1 write / 2 cycles.
  always_comb begin
    elig_a     = req_a && !gnt_a;
    elig_b     = req_b && !gnt_b;
    win_a      = elig_a && (!elig_b || (last_gnt_q == REQ_B));
    win_b      = elig_b && !win_a;
    last_gnt_d = last_gnt_q;
    if (win_a) begin
      last_gnt_d = REQ_A;
    end else if (win_b) begin
      last_gnt_d = REQ_B;
    end
  end

  assign cur_digit = digit_q[sel_q];

  seg_hex_decode u_dec (
    .val (cur_digit[3:0]),
    .seg (seg)
  );

  always_comb begin
    slot_start = (pre_q == '0) && (sub_q == '0);
    pre_d      = pre_q + PreW'(1);
    sub_d      = sub_q;
    sel_d      = sel_q;
    if (pre_q == PreMax) begin
      pre_d = '0;
      sub_d = sub_q + 4'd1;
      if (sub_q == 4'd15) begin
        sel_d = (sel_q == SelMax) ? '0 : sel_q + SelW'(1);
      end
    end
    bright_d = slot_start ? bright : bright_q;
    ca_d     = slot_start ? {cur_digit[DIGIT_W-1], seg} : ca;
    // Slot start is the dead-time cycle; after that the PWM phase gates the anode.
    an_d     = '0;
    if (!slot_start && (sub_q < bright_q)) begin
      an_d = N_DIGITS'(1) << sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pre_q      <= '0;
      sub_q      <= '0;
      sel_q      <= '0;
      bright_q   <= '0;
      last_gnt_q <= REQ_B;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      an         <= '0;
      ca         <= '0;
    end else begin
      pre_q      <= pre_d;
      sub_q      <= sub_d;
      sel_q      <= sel_d;
      bright_q   <= bright_d;
      last_gnt_q <= last_gnt_d;
      gnt_a      <= win_a;
      gnt_b      <= win_b;
      an         <= an_d;
      ca         <= ca_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        digit_q[i] <= '0;
      end
    end else if (win_a) begin
      digit_q[idx_a] <= {dp_a, val_a};
    end else if (win_b) begin
      digit_q[idx_b] <= {dp_b, val_b};
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected display and grant values are queued
// per cycle and a monitor compares them against the DUT on the falling edge.
module tb_seg_scan_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] ca;
    string      name;
  } disp_t;

  typedef struct {
    int   cyc;
    logic ga;
    logic gb;
  } gnt_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       req_a, req_b;
  logic [1:0] idx_a, idx_b;
  logic [3:0] val_a, val_b;
  logic       dp_a, dp_b;
  logic       gnt_a, gnt_b;
  logic [3:0] bright;
  logic [3:0] an;
  logic [7:0] ca;

  disp_t disp_q[$];
  gnt_t  gnt_q[$];
  disp_t de;
  gnt_t  ge;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic  exp_ga [0:339];
  logic  exp_gb [0:339];

  seg_scan_ctrl #(
    .SCAN_DIV (32),
    .N_DIGITS (4)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .req_a  (req_a),
    .idx_a  (idx_a),
    .val_a  (val_a),
    .dp_a   (dp_a),
    .req_b  (req_b),
    .idx_b  (idx_b),
    .val_b  (val_b),
    .dp_b   (dp_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .bright (bright),
    .an     (an),
    .ca     (ca)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; outputs seen at the falling edge belong to it.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (disp_q.size() > 0 && disp_q[0].cyc <= cyc) begin
      de = disp_q.pop_front();
      checks++;
      if (de.cyc != cyc || an !== de.an || ca !== de.ca) begin
        errors++;
        $display("FAIL %s cyc=%0d: an=%b ca=%h, expected an=%b ca=%h (due cyc %0d)",
                 de.name, cyc, an, ca, de.an, de.ca, de.cyc);
      end
    end
    while (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc) begin
      ge = gnt_q.pop_front();
      checks++;
      if (ge.cyc != cyc || gnt_a !== ge.ga || gnt_b !== ge.gb) begin
        errors++;
        $display("FAIL gnt cyc=%0d: gnt_a=%b gnt_b=%b, expected gnt_a=%b gnt_b=%b (due cyc %0d)",
                 cyc, gnt_a, gnt_b, ge.ga, ge.gb, ge.cyc);
      end
    end
  end

  task automatic push_disp(input int c, input logic [3:0] a, input logic [7:0] k,
                           input string name);
    disp_t e;
    e.cyc  = c;
    e.an   = a;
    e.ca   = k;
    e.name = name;
    disp_q.push_back(e);
  endtask

  // One scan slot: base is the cycle right after the div_cnt==0 edge.
  task automatic push_slot(input int base, input int sel, input logic [7:0] k, input int bq,
                           input int n, input string name);
    logic [3:0] one;
    one = 4'b0001 << sel;
    for (int d = 0; d < n; d++) begin
      push_disp(base + d, (d >= 1 && d / 2 < bq) ? one : 4'b0000, k, name);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    clr = 1'b1; req_a = 1'b0; req_b = 1'b0;
    idx_a = 2'd0; val_a = 4'd0; dp_a = 1'b0;
    idx_b = 2'd0; val_b = 4'd0; dp_b = 1'b0;
    bright = 4'd15;

    for (int i = 1; i <= 3; i++) push_disp(i, 4'b0000, 8'h00, "reset");
    push_slot(4,   0, 8'h3F, 15, 32, "slot0_blank");
    push_slot(36,  1, 8'h5B, 15, 32, "slot1_two");
    push_slot(68,  2, 8'h4F, 15, 32, "slot2_three");
    push_slot(100, 3, 8'h71, 15, 32, "slot3_f");
    push_slot(132, 0, 8'h06, 15, 32, "wrap_one_midwrite_hidden");
    push_slot(164, 1, 8'h5B, 4,  32, "bright4");
    push_slot(196, 2, 8'h4F, 0,  32, "bright0");
    push_slot(228, 3, 8'h71, 15, 32, "bright15_again");
    push_slot(260, 0, 8'h7F, 15, 32, "midwrite_visible");
    push_slot(292, 1, 8'h5B, 15, 9,  "before_clr");
    push_disp(301, 4'b0000, 8'h00, "clr_mid_slot");
    push_slot(302, 0, 8'h3F, 15, 32, "restart_sel0");
    push_slot(334, 1, 8'h07, 15, 32, "later_write_wins");
    push_slot(366, 2, 8'h6D, 15, 32, "arb_write_a");
    push_slot(398, 3, 8'hEF, 15, 32, "arb_write_b_dp");

    for (int i = 0; i < 340; i++) begin
      exp_ga[i] = 1'b0;
      exp_gb[i] = 1'b0;
    end
    exp_ga[7] = 1'b1;   exp_gb[9] = 1'b1;   exp_ga[11] = 1'b1;  exp_gb[13] = 1'b1;
    exp_ga[141] = 1'b1;
    for (int i = 302; i <= 309; i++) begin
      if (i % 2 == 0) exp_ga[i] = 1'b1;
      else            exp_gb[i] = 1'b1;
    end
    for (int i = 313; i <= 319; i += 2) exp_ga[i] = 1'b1;
    exp_ga[331] = 1'b1; exp_gb[332] = 1'b1;
    for (int i = 1; i <= 335; i++) begin
      gnt_t g;
      g.cyc = i;
      g.ga  = exp_ga[i];
      g.gb  = exp_gb[i];
      gnt_q.push_back(g);
    end

    wait_cyc(3);   clr = 1'b0;
    wait_cyc(6);   req_a = 1'b1; idx_a = 2'd0; val_a = 4'h1;
    wait_cyc(7);   req_a = 1'b0;
    wait_cyc(8);   req_b = 1'b1; idx_b = 2'd1; val_b = 4'h2;
    wait_cyc(9);   req_b = 1'b0;
    wait_cyc(10);  req_a = 1'b1; idx_a = 2'd2; val_a = 4'h3;
    wait_cyc(11);  req_a = 1'b0;
    wait_cyc(12);  req_b = 1'b1; idx_b = 2'd3; val_b = 4'hF;
    wait_cyc(13);  req_b = 1'b0;
    wait_cyc(140); req_a = 1'b1; idx_a = 2'd0; val_a = 4'h8;
    wait_cyc(141); req_a = 1'b0;
    wait_cyc(150); bright = 4'd4;
    wait_cyc(170); bright = 4'd0;
    wait_cyc(200); bright = 4'd15;
    wait_cyc(300);
    clr = 1'b1; req_a = 1'b1; idx_a = 2'd2; val_a = 4'h5; dp_a = 1'b0;
    idx_b = 2'd3; val_b = 4'h9; dp_b = 1'b1;
    wait_cyc(301); clr = 1'b0; req_b = 1'b1;
    wait_cyc(309); req_a = 1'b0; req_b = 1'b0;
    wait_cyc(312); req_a = 1'b1;
    wait_cyc(320); req_a = 1'b0;
    wait_cyc(330); req_a = 1'b1; idx_a = 2'd1; val_a = 4'h4;
    wait_cyc(331); req_a = 1'b0; req_b = 1'b1; idx_b = 2'd1; val_b = 4'h7; dp_b = 1'b0;
    wait_cyc(332); req_b = 1'b0;
    wait_cyc(433);

    checks++;
    if (disp_q.size() != 0 || gnt_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d display and %0d grant entries left, expected 0",
               disp_q.size(), gnt_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation reached time limit at cyc=%0d, expected end by 433", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
